dcache_ctrl: RTL



---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_if.sv | 39 +++
 rtl/dcache_store.sv | 63 ++++++
 rtl/dcache_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
//   state_e   : controller FSM states (IDLE, WB, FETCH, UPDATE)
//   OFFSET_W  : byte-offset bits inside a block
//   BLOCK_W   : block width in bits
//   idx_w()   : index width for a given block count
//   tag_w()   : tag width for a given address width and block count
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_FETCH  = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;

  function automatic int idx_w(input int num_blocks);
    return (num_blocks > 1) ? $clog2(num_blocks) : 1;
  endfunction

  function automatic int tag_w(input int addr_w, input int num_blocks);
    return addr_w - OFFSET_W - idx_w(num_blocks);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Bus bundles around the data cache.
//   dcache_cpu_if : CPU data port. master = CPU, slave = cache.
//                   read, write, address, writedata -> cache
//                   readdata, busywait              -> CPU
//   dcache_mem_if : block memory port. master = cache, slave = memory.
//                   mem_read, mem_write, mem_address, mem_writedata -> memory
//                   mem_readdata, mem_busywait                      -> cache
//
// Handshake: a request (read/write, or mem_read/mem_write) is held stable by
// its issuer while the responder's busywait is high; the transfer completes in
// the cycle where the request is high and busywait is low, and the issuer may
// change or drop the request only after that cycle's rising edge.
interface dcache_cpu_if #(parameter int ADDR_W = 8) ();
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [7:0]        writedata;
  logic [7:0]        readdata;
  logic              busywait;

  modport master (output read, write, address, writedata,
                  input  readdata, busywait);
  modport slave  (input  read, write, address, writedata,
                  output readdata, busywait);
endinterface

interface dcache_mem_if #(parameter int ADDR_W = 8) ();
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_busywait;

  modport master (output mem_read, mem_write, mem_address, mem_writedata,
                  input  mem_readdata, mem_busywait);
  modport slave  (input  mem_read, mem_write, mem_address, mem_writedata,
                  output mem_readdata, mem_busywait);
endinterface

// File: rtl/dcache_store.sv
// Cache storage: per-block data, tag, valid and dirty.
// Asynchronous read of the addressed block, synchronous writes, and an
// asynchronous clear of valid/dirty on reset.
//   clk, rst_n            : clock, async active-low reset
//   idx                   : block index (read and write)
//   rd_data/rd_tag/...    : addressed block contents
//   byte_we/off/data      : store one byte into the block, mark it dirty
//   fill_we/data/tag      : replace the block from memory, valid & clean
module dcache_store
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int TAG_W      = 3,
  parameter int IDX_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    idx,
  output logic [BLOCK_W-1:0]  rd_data,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] byte_off,
  input  logic [7:0]          byte_data,
  input  logic                fill_we,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic [TAG_W-1:0]    fill_tag
);

  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;

  assign rd_data  = data_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

  // Only the status bits are cleared; data and tag are don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx] <= fill_data;
      tag_q[idx]  <= fill_tag;
    end else if (byte_we) begin
      data_q[idx][{byte_off, 3'b000} +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller.
// Owns the miss FSM, hit detection and byte-lane selection; storage lives in
// dcache_store.
//   CLK, RESET  : clock, asynchronous active-low reset
//   cpu         : CPU data port (slave side)
//   mem         : block memory port (master side)
//   dbg_state   : current FSM state (dcache_pkg::state_e encoding)
//   hit_count, miss_count : saturating statistics, present only when the
//                           DCACHE_STATS_EN macro is defined
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem,
  output logic [1:0]   dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IDX_W = idx_w(NUM_BLOCKS);
  localparam int TAG_W = tag_w(ADDR_W, NUM_BLOCKS);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] WB     = ST_WB;
  localparam logic [1:0] FETCH  = ST_FETCH;
  localparam logic [1:0] UPDATE = ST_UPDATE;

  logic [1:0] state_q, state_d;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                req;

  logic [BLOCK_W-1:0]  blk_data;
  logic [TAG_W-1:0]    blk_tag;
  logic                blk_valid;
  logic                blk_dirty;

  logic                hit;
  logic                miss;
  logic [7:0]          lane;
  logic [BLOCK_W-1:0]  fill_q;

  assign req_tag = cpu.address[ADDR_W-1 -: TAG_W];
  assign req_idx = cpu.address[OFFSET_W +: IDX_W];
  assign req_off = cpu.address[OFFSET_W-1:0];
  assign req     = cpu.read | cpu.write;

  dcache_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W)
  ) u_store (
    .clk       (CLK),
    .rst_n     (RESET),
    .idx       (req_idx),
    .rd_data   (blk_data),
    .rd_tag    (blk_tag),
    .rd_valid  (blk_valid),
    .rd_dirty  (blk_dirty),
    .byte_we   (hit & cpu.write),
    .byte_off  (req_off),
    .byte_data (cpu.writedata),
    .fill_we   (state_q == UPDATE),
    .fill_data (fill_q),
    .fill_tag  (req_tag)
  );

  // Hits are only meaningful in IDLE; other states are servicing a miss.
  assign hit  = (state_q == IDLE) & req & blk_valid & (blk_tag == req_tag);
  assign miss = (state_q == IDLE) & req & ~(blk_valid & (blk_tag == req_tag));

  always_comb begin
    lane = blk_data[7:0];
    case (req_off)
      2'd0:    lane = blk_data[7:0];
      2'd1:    lane = blk_data[15:8];
      2'd2:    lane = blk_data[23:16];
      default: lane = blk_data[31:24];
    endcase
  end

  // A simultaneous read and write is a write, so no load data is returned.
  assign cpu.readdata = (hit & cpu.read & ~cpu.write) ? lane : 8'h00;
  assign cpu.busywait = miss | (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = blk_dirty ? WB : FETCH;
      WB:      if (!mem.mem_busywait) state_d = FETCH;
      FETCH:   if (!mem.mem_busywait) state_d = UPDATE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Refill data is only guaranteed during the final FETCH cycle, so it is
  // captured there and written into the array during UPDATE.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) fill_q <= '0;
    else if (state_q == FETCH && !mem.mem_busywait) fill_q <= mem.mem_readdata;
  end

  // Memory outputs decode from state only; address and stored block are
  // held constant by the stalled CPU, so they stay stable per transfer.
  always_comb begin
    mem.mem_read      = (state_q == FETCH);
    mem.mem_write     = (state_q == WB);
    mem.mem_address   = '0;
    mem.mem_writedata = '0;
    if (state_q == WB) begin
      mem.mem_address   = {blk_tag, req_idx};
      mem.mem_writedata = blk_data;
    end else if (state_q == FETCH) begin
      mem.mem_address   = {req_tag, req_idx};
    end
  end

  assign dbg_state = state_q;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
